// File: rtl/count_sequencer.sv
// Stopwatch-style control FSM: debounces KEY buttons, prescales the count
// enable, freezes a lap value on the display and stops at a programmable limit.
module count_sequencer #(
   parameter int COUNT_W  = 16,
   parameter int TICK_DIV = 12500000,
   parameter int DEBOUNCE = 250000
) (
   input  logic               CLK,
   input  logic               CLR_N,
   input  logic               key_start_n,
   input  logic               key_lap_n,
   input  logic               key_clear_n,
   input  logic [COUNT_W-1:0] limit,
   input  logic [COUNT_W-1:0] count_in,
   output logic               cnt_en,
   output logic               cnt_clr,
   output logic [COUNT_W-1:0] disp_value,
   output logic [2:0]         state,
   output logic               done
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int DB_W  = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      LAP   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t cur_state, nxt_state;

   // Key index 0 = start, 1 = lap, 2 = clear; all buttons idle high
   logic [2:0]         key_raw;
   logic [2:0]         sync_a, sync_b, deb_level, press;
   logic [DB_W-1:0]    deb_cnt [3];

   logic               cmd_start, cmd_lap, cmd_clear;
   logic               at_limit, active, capture_lap, tick_nxt;
   logic [PRE_W-1:0]   presc, presc_nxt;
   logic [COUNT_W-1:0] lap_reg;

   assign key_raw = {key_clear_n, key_lap_n, key_start_n};

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         sync_a    <= '1;
         sync_b    <= '1;
         deb_level <= '1;
         press     <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync_a <= key_raw;
         sync_b <= sync_a;
         for (int i = 0; i < 3; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] != deb_level[i]) begin
               if (deb_cnt[i] == DB_LAST) begin
                  deb_level[i] <= sync_b[i];
                  deb_cnt[i]   <= '0;
                  press[i]     <= ~sync_b[i];
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Clear outranks start, which outranks lap
   assign cmd_clear = press[2];
   assign cmd_start = press[0] & ~press[2];
   assign cmd_lap   = press[1] & ~press[2] & ~press[0];
   assign at_limit  = (count_in == limit);
   assign active    = (cur_state == RUN) || (cur_state == LAP);

   always_comb begin
      nxt_state   = cur_state;
      capture_lap = 1'b0;
      case (cur_state)
         IDLE:  if (cmd_start) nxt_state = RUN;
         RUN: begin
            if (at_limit)       nxt_state = DONE;
            else if (cmd_start) nxt_state = PAUSE;
            else if (cmd_lap) begin
               nxt_state   = LAP;
               capture_lap = 1'b1;
            end
         end
         LAP: begin
            if (at_limit)       nxt_state = DONE;
            else if (cmd_start) nxt_state = PAUSE;
            else if (cmd_lap)   nxt_state = RUN;
         end
         PAUSE: if (cmd_start) nxt_state = RUN;
         DONE:  nxt_state = DONE;
         default: nxt_state = IDLE;
      endcase
      if (cmd_clear) begin
         nxt_state   = IDLE;
         capture_lap = 1'b0;
      end
   end

   // Prescaler freezes in PAUSE/DONE so a resumed run keeps its tick phase
   always_comb begin
      presc_nxt = presc;
      tick_nxt  = 1'b0;
      if (cmd_clear || cur_state == IDLE) begin
         presc_nxt = '0;
      end else if (active && !at_limit) begin
         if (presc == PRE_LAST) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
         end else begin
            presc_nxt = presc + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         cur_state  <= IDLE;
         presc      <= '0;
         cnt_en     <= 1'b0;
         cnt_clr    <= 1'b0;
         done       <= 1'b0;
         lap_reg    <= '0;
         disp_value <= '0;
      end else begin
         cur_state  <= nxt_state;
         presc      <= presc_nxt;
         cnt_en     <= tick_nxt;
         cnt_clr    <= cmd_clear;
         done       <= (nxt_state == DONE);
         if (capture_lap) lap_reg <= count_in;
         disp_value <= (cur_state == LAP) ? lap_reg : count_in;
      end
   end

   assign state = cur_state;

endmodule
